// File: rtl/fwd_pkg.sv
// Shared types and helpers for the E-stage forwarding unit.
package fwd_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned LANES_DEF = 2;
    localparam int unsigned XLEN_DEF  = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
        logic             v;
    } fwd_tag_t;

    // A stage tag can supply register rs (x0 is never forwarded).
    function automatic logic fwd_match(input fwd_tag_t tag, input logic [REG_W-1:0] rs);
        return tag.v && tag.wr && (tag.rd != REG_ZERO) && (tag.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Selects one E operand from the youngest matching M/W producer or the register file.
// FWD_STATS_EN adds a forward-hit flag used by the top-level counters.
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned XLEN  = XLEN_DEF
) (
    input  fwd_tag_t [LANES-1:0]      tagM,
    input  fwd_tag_t [LANES-1:0]      tagW,
    input  logic [REG_W-1:0]          rs,
    input  logic [XLEN-1:0]           source,
    input  logic [LANES*XLEN-1:0]     resultM,
    input  logic [LANES*XLEN-1:0]     distW,
    output logic [XLEN-1:0]           operand_c,
`ifdef FWD_STATS_EN
    output logic                      fwdHit_c,
`endif
    output logic                      loadHit_c
);

    // Scan oldest to youngest so the last hit written is the highest-priority one.
    always_comb begin
        operand_c = source;
        loadHit_c = 1'b0;
`ifdef FWD_STATS_EN
        fwdHit_c  = 1'b0;
`endif
        for (int unsigned j = 0; j < LANES; j++) begin
            if (fwd_match(tagW[j], rs)) begin
                operand_c = distW[j*XLEN +: XLEN];
                loadHit_c = 1'b0;
`ifdef FWD_STATS_EN
                fwdHit_c  = 1'b1;
`endif
            end
        end
        for (int unsigned j = 0; j < LANES; j++) begin
            if (fwd_match(tagM[j], rs)) begin
                operand_c = resultM[j*XLEN +: XLEN];
                loadHit_c = tagM[j].ld;
`ifdef FWD_STATS_EN
                fwdHit_c  = ~tagM[j].ld;
`endif
            end
        end
    end

endmodule

// File: rtl/e_forward_unit_nlane.sv
// N-lane E-stage forwarding and load-use hazard unit with an internal E->M->W tag pipeline.
// Define FWD_STATS_EN to add saturating forward-hit and load-use-stall counters.
module e_forward_unit_nlane
    import fwd_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned REGW  = REG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic [LANES*REGW-1:0]     rdE_i,
    input  logic [LANES-1:0]          reg_writeE_i,
    input  logic [LANES-1:0]          is_loadE_i,
    input  logic [LANES-1:0]          validE_i,
    input  logic [LANES*2*REGW-1:0]   rsE_i,
    input  logic [LANES*2*XLEN-1:0]   sourceE_i,
    input  logic [LANES*XLEN-1:0]     resultM_i,
    input  logic [LANES*XLEN-1:0]     distW_i,
    output logic [LANES*2*XLEN-1:0]   reg_dataE_o,
`ifdef FWD_STATS_EN
    output logic [31:0]               fwd_hits_o,
    output logic [31:0]               lu_stalls_o,
`endif
    output logic                      load_use_o
);

    fwd_tag_t [LANES-1:0] tagM;
    fwd_tag_t [LANES-1:0] tagW;
    fwd_tag_t [LANES-1:0] tagE;
    logic [2*LANES-1:0]   loadHit;
`ifdef FWD_STATS_EN
    logic [2*LANES-1:0]   fwdHit;
    logic                 anyFwd;
`endif

    always_comb begin
        tagE = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            tagE[i].rd = rdE_i[i*REGW +: REGW];
            tagE[i].wr = reg_writeE_i[i];
            tagE[i].ld = is_loadE_i[i];
            tagE[i].v  = validE_i[i] & ~flush_i;
        end
    end

    // A stalled edge retires M into W and leaves a bubble in M while the core holds E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagM <= '0;
            tagW <= '0;
        end else if (!hold_i) begin
            tagW <= tagM;
            if (load_use_o) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    tagM[i].v <= 1'b0;
                end
            end else begin
                tagM <= tagE;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        for (genvar src = 0; src < 2; src++) begin : g_src
            fwd_operand_sel #(
                .LANES (LANES),
                .XLEN  (XLEN)
            ) u_sel (
                .tagM      (tagM),
                .tagW      (tagW),
                .rs        (rsE_i[(2*i+src)*REGW +: REGW]),
                .source    (sourceE_i[(2*i+src)*XLEN +: XLEN]),
                .resultM   (resultM_i),
                .distW     (distW_i),
                .operand_c (reg_dataE_o[(2*i+src)*XLEN +: XLEN]),
`ifdef FWD_STATS_EN
                .fwdHit_c  (fwdHit[2*i+src]),
`endif
                .loadHit_c (loadHit[2*i+src])
            );
        end
    end

    always_comb begin
        load_use_o = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            load_use_o = load_use_o | (validE_i[i] & (loadHit[2*i] | loadHit[2*i+1]));
        end
        load_use_o = load_use_o & ~hold_i;
    end

`ifdef FWD_STATS_EN
    always_comb begin
        anyFwd = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            anyFwd = anyFwd | (validE_i[i] & (fwdHit[2*i] | fwdHit[2*i+1]));
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hits_o  <= '0;
            lu_stalls_o <= '0;
        end else begin
            if (!hold_i && anyFwd && (fwd_hits_o != '1)) begin
                fwd_hits_o <= fwd_hits_o + 32'd1;
            end
            if (load_use_o && (lu_stalls_o != '1)) begin
                lu_stalls_o <= lu_stalls_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_e_forward_unit_nlane.sv
// Self-checking bench: directed bundles checked by a priority-search reference model every cycle.
module tb_e_forward_unit_nlane;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int REGW  = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    hold;
    logic                    flush;
    logic [LANES*REGW-1:0]   rdE;
    logic [LANES-1:0]        wrE;
    logic [LANES-1:0]        ldE;
    logic [LANES-1:0]        validE;
    logic [LANES*2*REGW-1:0] rsE;
    logic [LANES*2*XLEN-1:0] srcE;
    logic [LANES*XLEN-1:0]   resM;
    logic [LANES*XLEN-1:0]   distW;
    logic [LANES*2*XLEN-1:0] regData;
    logic                    loadUse;
`ifdef FWD_STATS_EN
    logic [31:0]             fwdHits;
    logic [31:0]             luStalls;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    e_forward_unit_nlane #(.LANES(LANES), .XLEN(XLEN), .REGW(REGW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold),
        .flush_i      (flush),
        .rdE_i        (rdE),
        .reg_writeE_i (wrE),
        .is_loadE_i   (ldE),
        .validE_i     (validE),
        .rsE_i        (rsE),
        .sourceE_i    (srcE),
        .resultM_i    (resM),
        .distW_i      (distW),
        .reg_dataE_o  (regData),
`ifdef FWD_STATS_EN
        .fwd_hits_o   (fwdHits),
        .lu_stalls_o  (luStalls),
`endif
        .load_use_o   (loadUse)
    );

    // Reference model: what each pipeline stage holds, lane by lane.
    logic [REGW-1:0] mRd [LANES];
    logic [REGW-1:0] wRd [LANES];
    bit mWr [LANES], mLd [LANES], mV [LANES];
    bit wWr [LANES], wLd [LANES], wV [LANES];

    function automatic logic [XLEN-1:0] srcVal(int l, int s);
        return 32'hA000_0000 + 32'(2*l + s);
    endfunction

    function automatic logic [XLEN-1:0] expOp(int l, int s, output bit ldHit);
        logic [REGW-1:0] rs;
        logic [XLEN-1:0] val;
        bit found;
        rs    = rsE[(2*l+s)*REGW +: REGW];
        val   = srcE[(2*l+s)*XLEN +: XLEN];
        ldHit = 1'b0;
        found = 1'b0;
        if (rs != 0) begin
            for (int m = LANES-1; m >= 0; m--) begin
                if (!found && mV[m] && mWr[m] && mRd[m] == rs) begin
                    found = 1'b1;
                    ldHit = mLd[m];
                    val   = resM[m*XLEN +: XLEN];
                end
            end
            for (int w = LANES-1; w >= 0; w--) begin
                if (!found && wV[w] && wWr[w] && wRd[w] == rs) begin
                    found = 1'b1;
                    val   = distW[w*XLEN +: XLEN];
                end
            end
        end
        return val;
    endfunction

    function automatic bit expLoadUse();
        bit lu, ld;
        logic [XLEN-1:0] unused;
        lu = 1'b0;
        if (!hold) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < 2; s++) begin
                    unused = expOp(l, s, ld);
                    if (validE[l] && ld) lu = 1'b1;
                end
            end
        end
        return lu;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                mV[i] <= 1'b0; wV[i] <= 1'b0;
                mWr[i] <= 1'b0; wWr[i] <= 1'b0;
                mLd[i] <= 1'b0; wLd[i] <= 1'b0;
                mRd[i] <= '0; wRd[i] <= '0;
            end
        end else if (!hold) begin
            for (int i = 0; i < LANES; i++) begin
                wRd[i] <= mRd[i]; wWr[i] <= mWr[i]; wLd[i] <= mLd[i]; wV[i] <= mV[i];
            end
            if (expLoadUse()) begin
                for (int i = 0; i < LANES; i++) mV[i] <= 1'b0;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    mRd[i] <= rdE[i*REGW +: REGW];
                    mWr[i] <= wrE[i];
                    mLd[i] <= ldE[i];
                    mV[i]  <= validE[i] & ~flush;
                end
            end
        end
    end

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] op(int l, int s);
        return regData[(2*l+s)*XLEN +: XLEN];
    endfunction

    // Per-cycle comparison against the model; operands behind a load hit are don't-care.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < 2; s++) begin
                    bit ld;
                    logic [XLEN-1:0] e;
                    e = expOp(l, s, ld);
                    if (!ld) chk($sformatf("model op l%0d s%0d", l, s), op(l, s), e);
                end
            end
            chk("model load_use", 32'(loadUse), 32'(expLoadUse()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clrE();
        rdE = '0; wrE = '0; ldE = '0; validE = '0; rsE = '0;
    endtask

    task automatic prod(int l, logic [REGW-1:0] rd, bit ld);
        rdE[l*REGW +: REGW] = rd;
        wrE[l]    = 1'b1;
        ldE[l]    = ld;
        validE[l] = 1'b1;
    endtask

    task automatic cons(int l, logic [REGW-1:0] rs1, logic [REGW-1:0] rs2);
        rsE[l*2*REGW +: REGW]        = rs1;
        rsE[l*2*REGW + REGW +: REGW] = rs2;
        validE[l] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        clrE();
        resM = '0; distW = '0;
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < 2; s++)
                srcE[(2*l+s)*XLEN +: XLEN] = srcVal(l, s);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state: no tags valid, operands come from the register file.
        cons(1, 5'd5, 5'd0);
        @(negedge clk);
        chk("reset op1", op(1, 0), srcVal(1, 0));
        chk("reset load_use", 32'(loadUse), 32'd0);
        tick();

        // 1: ALU producer in M forwards to the next bundle.
        clrE(); prod(0, 5'd5, 1'b0); tick();
        clrE(); cons(1, 5'd5, 5'd0); resM[31:0] = 32'h11;
        @(negedge clk);
        chk("t1 op1", op(1, 0), 32'h11);
        chk("t1 load_use", 32'(loadUse), 32'd0);
        tick();

        // 2: both M lanes write x7, then both W lanes: higher lane wins.
        clrE(); prod(0, 5'd7, 1'b0); prod(1, 5'd7, 1'b0); tick();
        clrE(); cons(0, 5'd0, 5'd7); resM = {32'hB, 32'hA};
        @(negedge clk);
        chk("t2 M dup rd", op(0, 1), 32'hB);
        tick();
        distW = {32'hD, 32'hC};
        @(negedge clk);
        chk("t2 W dup rd", op(0, 1), 32'hD);
        tick();

        // 3: load in M -> one stall cycle, then forwarded from W.
        clrE(); prod(0, 5'd3, 1'b1); tick();
        clrE(); cons(1, 5'd0, 5'd3);
        @(negedge clk);
        chk("t3 load_use set", 32'(loadUse), 32'd1);
        tick();
        distW[31:0] = 32'hDEAD;
        @(negedge clk);
        chk("t3 op2 from W", op(1, 1), 32'hDEAD);
        chk("t3 load_use clear", 32'(loadUse), 32'd0);
        tick();

        // 4: x0 producer is never forwarded.
        clrE(); prod(0, 5'd0, 1'b0); tick();
        clrE(); cons(1, 5'd0, 5'd0); resM[31:0] = 32'h55;
        @(negedge clk);
        chk("t4 x0 op1", op(1, 0), srcVal(1, 0));
        tick();

        // 5: hold freezes tags for 3 cycles, then a flushed producer never reaches M.
        clrE(); prod(0, 5'd9, 1'b0); tick();
        clrE(); cons(1, 5'd9, 5'd0); resM[31:0] = 32'h42; hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5 hold op1 c%0d", k), op(1, 0), 32'h42);
            tick();
        end
        hold = 1'b0; flush = 1'b1; prod(0, 5'd10, 1'b0);
        @(negedge clk);
        chk("t5 unhold op1", op(1, 0), 32'h42);
        tick();
        flush = 1'b0; clrE(); cons(1, 5'd10, 5'd0); cons(0, 5'd9, 5'd0);
        distW[31:0] = 32'h99;
        @(negedge clk);
        chk("t5 flushed no hit", op(1, 0), srcVal(1, 0));
        chk("t5 x9 from W", op(0, 0), 32'h99);
        tick();

        // 6: asynchronous reset in the middle of a load-use stall.
        clrE(); prod(0, 5'd4, 1'b1); tick();
        clrE(); cons(1, 5'd4, 5'd0);
        @(negedge clk);
        chk("t6 load_use before rst", 32'(loadUse), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 load_use in rst", 32'(loadUse), 32'd0);
        chk("t6 op1 in rst", op(1, 0), srcVal(1, 0));
`ifdef FWD_STATS_EN
        chk("t6 fwd_hits rst", fwdHits, 32'd0);
        chk("t6 lu_stalls rst", luStalls, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6 op1 after rst", op(1, 0), srcVal(1, 0));
        chk("t6 load_use after rst", 32'(loadUse), 32'd0);
        tick();

        // Mixed directed sweep checked by the model.
        for (int k = 0; k < 24; k++) begin
            clrE();
            hold  = (k % 7 == 3);
            flush = (k % 5 == 4);
            for (int l = 0; l < LANES; l++) begin
                if ((k + l) % 3 != 2) prod(l, 5'((k * 3 + l) % 5), (k % 4 == l));
                cons(l, 5'((k + l) % 5), 5'((k + 2 * l + 1) % 5));
            end
            resM  = {32'(k * 16 + 1), 32'(k * 16)};
            distW = {32'(k * 16 + 9), 32'(k * 16 + 8)};
            tick();
        end
        hold = 1'b0; flush = 1'b0; clrE();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
